// File: rtl/regfile_sequencer.sv
// Multi-cycle sequencer that fetches operands from an external register file,
// runs LDI/ADD/SUB/MOV through a small ALU and writes the result back.
module regfile_sequencer #(
   parameter int N = 4
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [1:0]   i_opcode,
   input  logic [1:0]   i_rd,
   input  logic [1:0]   i_rs1,
   input  logic [1:0]   i_rs2,
   input  logic [N-1:0] i_imm,
   output logic [1:0]   o_reg_read_0,
   output logic [1:0]   o_reg_read_1,
   input  logic [N-1:0] i_port_read_0,
   input  logic [N-1:0] i_port_read_1,
   output logic [1:0]   o_reg_write,
   output logic [N-1:0] o_port_write,
   output logic         o_write_enable,
   output logic         o_done,
   output logic         o_carry,
   output logic [1:0]   o_state
);

   // Handshake: an instruction transfers on a rising edge where i_valid and
   // o_ready are both 1; the requester holds i_valid and fields until then.

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      EXEC  = 2'd2,
      WRITE = 2'd3
   } state_t;

   localparam logic [1:0] OP_LDI = 2'b00;
   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [1:0] OP_SUB = 2'b10;

   state_t         state;
   logic [1:0]     opcode_q;
   logic [1:0]     rd_q;
   logic [1:0]     rs1_q;
   logic [1:0]     rs2_q;
   logic [N-1:0]   a_q;
   logic [N-1:0]   b_q;
   logic [N-1:0]   result_q;
   logic [N:0]     sum_w;
   logic [N:0]     diff_w;

   // The extra top bit of the difference is the borrow (set iff a < b).
   assign sum_w  = {1'b0, a_q} + {1'b0, b_q};
   assign diff_w = {1'b0, a_q} - {1'b0, b_q};

   assign o_reg_read_0 = (state == READ) ? rs1_q : 2'd0;
   assign o_reg_read_1 = (state == READ) ? rs2_q : 2'd0;
   assign o_reg_write  = rd_q;
   assign o_port_write = result_q;
   assign o_state      = state;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state          <= IDLE;
         o_ready        <= 1'b1;
         o_write_enable <= 1'b0;
         o_done         <= 1'b0;
         o_carry        <= 1'b0;
         opcode_q       <= 2'd0;
         rd_q           <= 2'd0;
         rs1_q          <= 2'd0;
         rs2_q          <= 2'd0;
         a_q            <= '0;
         b_q            <= '0;
         result_q       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_valid) begin
                  opcode_q <= i_opcode;
                  rd_q     <= i_rd;
                  rs1_q    <= i_rs1;
                  rs2_q    <= i_rs2;
                  o_ready  <= 1'b0;
                  // LDI needs no operands, so its result is the immediate itself.
                  if (i_opcode == OP_LDI) begin
                     result_q       <= i_imm;
                     state          <= WRITE;
                     o_write_enable <= 1'b1;
                     o_done         <= 1'b1;
                  end else begin
                     state <= READ;
                  end
               end
            end
            READ: begin
               a_q   <= i_port_read_0;
               b_q   <= i_port_read_1;
               state <= EXEC;
            end
            EXEC: begin
               case (opcode_q)
                  OP_ADD: begin
                     result_q <= sum_w[N-1:0];
                     o_carry  <= sum_w[N];
                  end
                  OP_SUB: begin
                     result_q <= diff_w[N-1:0];
                     o_carry  <= diff_w[N];
                  end
                  default: result_q <= a_q;
               endcase
               state          <= WRITE;
               o_write_enable <= 1'b1;
               o_done         <= 1'b1;
            end
            WRITE: begin
               state          <= IDLE;
               o_ready        <= 1'b1;
               o_write_enable <= 1'b0;
               o_done         <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a behavioural 4x4 register file.
module tb_regfile_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       valid;
   logic       ready;
   logic [1:0] opcode, rd, rs1, rs2;
   logic [3:0] imm;
   logic [1:0] rr0, rr1, wr_idx, state;
   logic [3:0] port0, port1, wr_data;
   logic       we, done, carry;

   logic [3:0] rf [4];
   int         wr_cnt = 0;
   int         n_tests = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   regfile_sequencer #(.N(4)) dut (
      .i_clk(clk), .i_reset(reset), .i_valid(valid), .o_ready(ready),
      .i_opcode(opcode), .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2), .i_imm(imm),
      .o_reg_read_0(rr0), .o_reg_read_1(rr1),
      .i_port_read_0(port0), .i_port_read_1(port1),
      .o_reg_write(wr_idx), .o_port_write(wr_data),
      .o_write_enable(we), .o_done(done), .o_carry(carry), .o_state(state)
   );

   assign port0 = rf[rr0];
   assign port1 = rf[rr1];

   always @(posedge clk) begin
      if (we) begin
         rf[wr_idx] <= wr_data;
         wr_cnt     <= wr_cnt + 1;
      end
   end

   // Issue one instruction, return latency (negedges after accept until the
   // write strobe), write index/data, done flag and read selects seen in READ.
   task automatic do_instr(input logic [1:0] op, input logic [1:0] d, input logic [1:0] s1,
                           input logic [1:0] s2, input logic [3:0] im, output int lat,
                           output logic [1:0] wi, output logic [3:0] wd, output logic dn,
                           output logic [1:0] sel0, output logic [1:0] sel1);
      int guard;
      @(negedge clk);
      valid = 1'b1; opcode = op; rd = d; rs1 = s1; rs2 = s2; imm = im;
      guard = 0;
      while (!ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk);
      #1 valid = 1'b0;
      lat = 0; sel0 = 2'd0; sel1 = 2'd0;
      while (lat < 10) begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            sel0 = rr0;
            sel1 = rr1;
         end
         if (we) break;
      end
      if (!we) lat = 99;
      wi = wr_idx; wd = wr_data; dn = done;
      @(negedge clk);
   endtask

   task automatic load(input logic [1:0] d, input logic [3:0] im);
      int l; logic [1:0] a, b, c; logic [3:0] w; logic dn;
      do_instr(2'b00, d, 2'd0, 2'd0, im, l, a, w, dn, b, c);
   endtask

   task automatic test_reset;
      reset = 1'b1; valid = 1'b0;
      opcode = 2'd0; rd = 2'd0; rs1 = 2'd0; rs2 = 2'd0; imm = 4'd0;
      repeat (3) @(negedge clk);
      n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", ready); end
      n_tests++; if (we !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b exp=0", we); end
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
      n_tests++; if (carry !== 1'b0) begin n_fail++; $display("FAIL reset_carry got=%b exp=0", carry); end
      n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state); end
      reset = 1'b0;
      @(negedge clk);
      n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got=%b exp=1", ready); end
   endtask

   task automatic test_ldi;
      int l; logic [1:0] wi, s0, s1; logic [3:0] wd; logic dn;
      do_instr(2'b00, 2'd2, 2'd0, 2'd0, 4'hA, l, wi, wd, dn, s0, s1);
      n_tests++; if (l != 1) begin n_fail++; $display("FAIL ldi_latency got=%0d exp=1", l); end
      n_tests++; if (wi !== 2'd2) begin n_fail++; $display("FAIL ldi_wr_idx got=%0d exp=2", wi); end
      n_tests++; if (wd !== 4'hA) begin n_fail++; $display("FAIL ldi_wr_data got=%h exp=a", wd); end
      n_tests++; if (dn !== 1'b1) begin n_fail++; $display("FAIL ldi_done got=%b exp=1", dn); end
      n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL ldi_ready_after got=%b exp=1", ready); end
      n_tests++; if (done !== 1'b0 || we !== 1'b0) begin n_fail++; $display("FAIL ldi_pulse_len done=%b we=%b exp=0 0", done, we); end
      n_tests++; if (rf[2] !== 4'hA) begin n_fail++; $display("FAIL ldi_rf2 got=%h exp=a", rf[2]); end
   endtask

   task automatic test_add;
      int l; logic [1:0] wi, s0, s1; logic [3:0] wd; logic dn;
      load(2'd0, 4'h9);
      load(2'd1, 4'h8);
      do_instr(2'b01, 2'd3, 2'd0, 2'd1, 4'h0, l, wi, wd, dn, s0, s1);
      n_tests++; if (l != 3) begin n_fail++; $display("FAIL add_latency got=%0d exp=3", l); end
      n_tests++; if (s0 !== 2'd0 || s1 !== 2'd1) begin n_fail++; $display("FAIL add_read_sel got=%0d,%0d exp=0,1", s0, s1); end
      n_tests++; if (wi !== 2'd3 || wd !== 4'h1) begin n_fail++; $display("FAIL add_write got=%0d:%h exp=3:1", wi, wd); end
      n_tests++; if (carry !== 1'b1) begin n_fail++; $display("FAIL add_carry got=%b exp=1", carry); end
      n_tests++; if (rf[3] !== 4'h1) begin n_fail++; $display("FAIL add_rf3 got=%h exp=1", rf[3]); end
   endtask

   task automatic test_sub;
      int l; logic [1:0] wi, s0, s1; logic [3:0] wd; logic dn;
      load(2'd0, 4'h3);
      load(2'd1, 4'h5);
      do_instr(2'b10, 2'd0, 2'd0, 2'd1, 4'h0, l, wi, wd, dn, s0, s1);
      n_tests++; if (wd !== 4'hE || wi !== 2'd0) begin n_fail++; $display("FAIL sub1_write got=%0d:%h exp=0:e", wi, wd); end
      n_tests++; if (carry !== 1'b1) begin n_fail++; $display("FAIL sub1_borrow got=%b exp=1", carry); end
      load(2'd0, 4'h3);
      do_instr(2'b10, 2'd2, 2'd1, 2'd0, 4'h0, l, wi, wd, dn, s0, s1);
      n_tests++; if (s0 !== 2'd1 || s1 !== 2'd0) begin n_fail++; $display("FAIL sub2_read_sel got=%0d,%0d exp=1,0", s0, s1); end
      n_tests++; if (wd !== 4'h2) begin n_fail++; $display("FAIL sub2_data got=%h exp=2", wd); end
      n_tests++; if (carry !== 1'b0) begin n_fail++; $display("FAIL sub2_borrow got=%b exp=0", carry); end
   endtask

   task automatic test_mov;
      int l; logic [1:0] wi, s0, s1; logic [3:0] wd; logic dn;
      load(2'd0, 4'h9);
      load(2'd1, 4'h8);
      do_instr(2'b01, 2'd3, 2'd0, 2'd1, 4'h0, l, wi, wd, dn, s0, s1);
      load(2'd1, 4'h6);
      n_tests++; if (carry !== 1'b1) begin n_fail++; $display("FAIL ldi_holds_carry got=%b exp=1", carry); end
      do_instr(2'b11, 2'd1, 2'd1, 2'd1, 4'h0, l, wi, wd, dn, s0, s1);
      n_tests++; if (l != 3) begin n_fail++; $display("FAIL mov_latency got=%0d exp=3", l); end
      n_tests++; if (wi !== 2'd1 || wd !== 4'h6) begin n_fail++; $display("FAIL mov_write got=%0d:%h exp=1:6", wi, wd); end
      n_tests++; if (carry !== 1'b1) begin n_fail++; $display("FAIL mov_carry got=%b exp=1", carry); end
      n_tests++; if (rf[1] !== 4'h6) begin n_fail++; $display("FAIL mov_rf1 got=%h exp=6", rf[1]); end
   endtask

   task automatic test_back_to_back;
      int n, cnt0, guard;
      load(2'd0, 4'hC);
      load(2'd1, 4'h7);
      cnt0 = wr_cnt;
      @(negedge clk);
      valid = 1'b1; opcode = 2'b01; rd = 2'd3; rs1 = 2'd0; rs2 = 2'd1; imm = 4'h0;
      @(posedge clk);
      #1 opcode = 2'b00; rd = 2'd2; imm = 4'h5;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ready && n < 10);
      n_tests++; if (n != 4) begin n_fail++; $display("FAIL b2b_busy_cycles got=%0d exp=4", n); end
      n_tests++; if (wr_cnt != cnt0 + 1) begin n_fail++; $display("FAIL b2b_writes_first got=%0d exp=%0d", wr_cnt, cnt0 + 1); end
      @(posedge clk);
      #1 valid = 1'b0;
      guard = 0;
      repeat (4) @(negedge clk);
      n_tests++; if (wr_cnt != cnt0 + 2) begin n_fail++; $display("FAIL b2b_writes_total got=%0d exp=%0d", wr_cnt, cnt0 + 2); end
      n_tests++; if (rf[3] !== 4'h3) begin n_fail++; $display("FAIL b2b_add_rf3 got=%h exp=3", rf[3]); end
      n_tests++; if (rf[2] !== 4'h5) begin n_fail++; $display("FAIL b2b_ldi_rf2 got=%h exp=5", rf[2]); end
      n_tests++; if (carry !== 1'b1) begin n_fail++; $display("FAIL b2b_carry got=%b exp=1", carry); end
   endtask

   task automatic test_reset_mid;
      int cnt0;
      load(2'd3, 4'h7);
      load(2'd0, 4'h9);
      load(2'd1, 4'h8);
      cnt0 = wr_cnt;
      @(negedge clk);
      valid = 1'b1; opcode = 2'b01; rd = 2'd3; rs1 = 2'd0; rs2 = 2'd1;
      @(posedge clk);
      #1 valid = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++; if (state !== 2'd2) begin n_fail++; $display("FAIL mid_in_exec got=%0d exp=2", state); end
      reset = 1'b1;
      #1;
      n_tests++; if (state !== 2'd0 || ready !== 1'b1) begin n_fail++; $display("FAIL mid_async state=%0d ready=%b exp=0 1", state, ready); end
      n_tests++; if (carry !== 1'b0) begin n_fail++; $display("FAIL mid_carry got=%b exp=0", carry); end
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      n_tests++; if (wr_cnt != cnt0) begin n_fail++; $display("FAIL mid_no_write got=%0d exp=%0d", wr_cnt, cnt0); end
      n_tests++; if (rf[3] !== 4'h7) begin n_fail++; $display("FAIL mid_rf3 got=%h exp=7", rf[3]); end
      n_tests++; if (ready !== 1'b1 || we !== 1'b0) begin n_fail++; $display("FAIL mid_after ready=%b we=%b exp=1 0", ready, we); end
   endtask

   initial begin
      test_reset();
      test_ldi();
      test_add();
      test_sub();
      test_mov();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/regfile_sequencer.md
REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 Parameter: N, 4, data width of register file ports and operands.
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_reset  input  1  asynchronous, active-high reset.
REQ-004 i_valid  input  1  instruction offered this cycle.
REQ-005 o_ready  output  1  sequencer can accept an instruction.
REQ-006 i_opcode  input  2  00 LDI, 01 ADD, 10 SUB, 11 MOV.
REQ-007 i_rd / i_rs1 / i_rs2  input  2 each  destination / source register indices.
REQ-008 i_imm  input  N  immediate for LDI.
REQ-009 o_reg_read_0 / o_reg_read_1  output  2 each  register file read selects.
REQ-010 i_port_read_0 / i_port_read_1  input  N each  register file read data (combinational from selects).
REQ-011 o_reg_write  output  2  register file write index.
REQ-012 o_port_write  output  N  register file write data.
REQ-013 o_write_enable  output  1  register file write strobe, sampled by register file on rising edge.
REQ-014 o_done  output  1  one-cycle pulse, instruction retiring this cycle.
REQ-015 o_carry  output  1  carry (ADD) / borrow (SUB) flag of last retired ALU op.

Function
REQ-016 FSM states SHALL be IDLE, READ, EXEC, WRITE; encoding free.
REQ-017 o_ready SHALL be 1 exactly when state is IDLE.
REQ-018 Accept occurs on a rising edge with i_valid=1 and o_ready=1; opcode, rd, rs1, rs2, imm SHALL be latched on that edge.
REQ-019 IDLE -> WRITE on accept of LDI; IDLE -> READ on accept of ADD, SUB, MOV; IDLE holds otherwise.
REQ-020 READ: o_reg_read_0=latched rs1, o_reg_read_1=latched rs2; i_port_read_0/1 SHALL be latched as operands A/B at end of READ; READ -> EXEC unconditionally.
REQ-021 EXEC: result register SHALL load A+B (ADD), A-B (SUB), A (MOV), all modulo 2^N; EXEC -> WRITE unconditionally.
REQ-022 ADD carry = bit N of the (N+1)-bit sum; SUB borrow = 1 iff A<B unsigned; o_carry SHALL update at end of EXEC for ADD/SUB only, hold for MOV/LDI.
REQ-023 LDI result SHALL be the latched immediate, loaded on the accept edge.
REQ-024 WRITE: o_write_enable=1, o_reg_write=latched rd, o_port_write=result, o_done=1; WRITE -> IDLE unconditionally.
REQ-025 o_write_enable and o_done SHALL be 0 in every state other than WRITE.
REQ-026 Latency accept-edge to register update edge: LDI 1 cycle, ADD/SUB/MOV 3 cycles; throughput one instruction per 2 (LDI) or 4 (ALU) cycles.
REQ-027 Sources equal to rd or to each other SHALL read pre-write values; no forwarding required since writes complete before next accept.
REQ-028 i_valid while o_ready=0 SHALL be ignored and not queued; requester must hold i_valid until accepted.
REQ-029 o_reg_read_0/1 SHALL be 0 outside READ.

Reset
REQ-030 i_reset=1 SHALL immediately force state IDLE, o_write_enable=0, o_done=0, o_carry=0, result=0, latched fields=0, independent of i_clk.
REQ-031 Reset mid-instruction SHALL abandon it with no register file write; o_ready=1 on first edge after release.
REQ-032 Register file contents are not cleared by this block.

Verification
REQ-033 Reset, LDI rd=2 imm=0xA -> one cycle later o_write_enable=1, o_reg_write=2, o_port_write=0xA, o_done=1; next cycle o_ready=1.
REQ-034 r0=0x9, r1=0x8, ADD rd=3 rs1=0 rs2=1 -> WRITE 3 cycles after accept, o_port_write=0x1, o_carry=1.
REQ-035 r0=0x3, r1=0x5, SUB rd=0 rs1=0 rs2=1 -> o_port_write=0xE, o_carry=1; then SUB rs1=1 rs2=0 -> 0x2, o_carry=0.
REQ-036 i_valid held high during READ/EXEC/WRITE with different instruction -> only accepted after return to IDLE, executed exactly once.
REQ-037 Assert i_reset during EXEC of ADD -> o_write_enable never 1 for that ADD, target register unchanged, o_ready=1 after release.
REQ-038 MOV rd=1 rs1=1 with o_carry=1 from prior ADD -> r1 unchanged value rewritten, o_carry stays 1.
